// File: rtl/nes_cart_pkg.sv
// nes_cart_pkg
// Shared types and constants for the cartridge ROM loader slice.
//   cart_state_t      : loader state (EMPTY, LOADING, READY)
//   DEFAULT_PRG_AW    : PRG memory address width (32 KiB)
//   DEFAULT_CHR_AW    : CHR memory address width (8 KiB)
//   DEFAULT_IDLE_TIMEOUT : quiet cycles in LOADING before READY
//   PRG_COUNT_W / CHR_COUNT_W : widths of the saturating write counters
//   MIRROR_HORIZONTAL / MIRROR_VERTICAL : encoding of the mirror input
package nes_cart_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } cart_state_t;

    localparam int DEFAULT_PRG_AW       = 15;
    localparam int DEFAULT_CHR_AW       = 13;
    localparam int DEFAULT_IDLE_TIMEOUT = 1024;

    localparam int PRG_COUNT_W = 16;
    localparam int CHR_COUNT_W = 14;

    localparam logic MIRROR_HORIZONTAL = 1'b0;
    localparam logic MIRROR_VERTICAL   = 1'b1;

endpackage

// File: rtl/cart_rom_loader_if.sv
// cart_rom_loader_if
// Bundles the loader conduit, the CPU/PPU cartridge bus and the loader
// status signals between the SoC side and the cartridge ROM loader.
//   master : SoC / NES core side (drives loader strobes and bus requests)
//   slave  : cart_rom_loader (returns read data, CIRAM address and status)
interface cart_rom_loader_if;
    import nes_cart_pkg::*;

    // Loader conduit
    logic [7:0]             rom_data;
    logic [15:0]            rom_addr;
    logic                   prg_rom_write;
    logic                   chr_rom_write;
    logic                   mirror;
    logic                   chr_ram;

    // CPU bus
    logic [15:0]            cpu_addr;
    logic                   cpu_rd;
    logic [7:0]             cpu_data;
    logic                   cpu_hit;

    // PPU bus
    logic [13:0]            ppu_addr;
    logic                   ppu_rd;
    logic                   ppu_wr;
    logic [7:0]             ppu_wdata;
    logic [7:0]             ppu_data;
    logic [10:0]            ciram_addr;

    // Status
    logic                   cart_ready;
    logic                   loading;
    logic [PRG_COUNT_W-1:0] prg_count;
    logic [CHR_COUNT_W-1:0] chr_count;

    modport master (
        output rom_data, rom_addr, prg_rom_write, chr_rom_write, mirror, chr_ram,
        output cpu_addr, cpu_rd,
        output ppu_addr, ppu_rd, ppu_wr, ppu_wdata,
        input  cpu_data, cpu_hit, ppu_data, ciram_addr,
        input  cart_ready, loading, prg_count, chr_count
    );

    modport slave (
        input  rom_data, rom_addr, prg_rom_write, chr_rom_write, mirror, chr_ram,
        input  cpu_addr, cpu_rd,
        input  ppu_addr, ppu_rd, ppu_wr, ppu_wdata,
        output cpu_data, cpu_hit, ppu_data, ciram_addr,
        output cart_ready, loading, prg_count, chr_count
    );

endinterface

// File: rtl/cart_dp_ram.sv
// cart_dp_ram
// Single-clock RAM with one write port and one registered read port.
// The read register only updates when re is high, so read data holds
// between requests. A same-address read and write returns the old byte.
//   clk   : clock
//   we    : write enable, waddr/wdata : write port
//   re    : read enable,  raddr       : read address
//   rdata : registered read data
module cart_dp_ram #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Storage has no reset: image contents survive a reset of the loader.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cart_rom_loader.sv
// cart_rom_loader
// Receives the byte-wide PRG/CHR image from the SoC loader, stores it in
// on-chip PRG and CHR memories, latches cartridge configuration and, once
// the loader has been quiet for IDLE_TIMEOUT cycles, serves NROM-style CPU
// and PPU reads with nametable mirroring.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : cart_rom_loader_if.slave (loader conduit, CPU/PPU bus, status)
// Optional feature macro: CART_CHR_RAM_EN -- when defined, a cartridge
// flagged chr_ram lets the PPU write CHR memory while READY.
module cart_rom_loader
    import nes_cart_pkg::*;
#(
    parameter int PRG_AW       = DEFAULT_PRG_AW,
    parameter int CHR_AW       = DEFAULT_CHR_AW,
    parameter int IDLE_TIMEOUT = DEFAULT_IDLE_TIMEOUT
) (
    input logic             clk,
    input logic             reset,
    cart_rom_loader_if.slave bus
);

    localparam int                IDLE_W    = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

    cart_state_t            state_q, state_d;
    logic                   prg_q, chr_q;
    logic                   prg_edge, chr_edge, any_edge, start_load;
    logic                   mirror_q, chr_ram_q, prg_big;
    logic [IDLE_W-1:0]      idle_cnt;
    logic [PRG_COUNT_W-1:0] prg_count_q;
    logic [CHR_COUNT_W-1:0] chr_count_q;
    logic                   cpu_req, ppu_req, cpu_hit_q, ppu_hit_q;
    logic [PRG_AW-1:0]      cpu_index;
    logic [7:0]             prg_rdata, chr_rdata;
    logic                   chr_we;
    logic [CHR_AW-1:0]      chr_waddr;
    logic [7:0]             chr_wdata;

    // Strobes are levels; only the rising edge counts as a write.
    assign prg_edge   = bus.prg_rom_write & ~prg_q;
    assign chr_edge   = bus.chr_rom_write & ~chr_q;
    assign any_edge   = prg_edge | chr_edge;
    // A write from EMPTY or READY starts a fresh load.
    assign start_load = any_edge & (state_q != LOADING);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: any write edge (re)enters LOADING; a full quiet window
    // in LOADING moves to READY.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (any_edge) state_d = LOADING;
            LOADING: if (!any_edge && idle_cnt == IDLE_LAST) state_d = READY;
            READY:   if (any_edge) state_d = LOADING;
            default: state_d = EMPTY;
        endcase
    end

    // Strobe history for edge detection and configuration latched on every
    // write edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prg_q     <= 1'b0;
            chr_q     <= 1'b0;
            mirror_q  <= MIRROR_HORIZONTAL;
            chr_ram_q <= 1'b0;
        end else begin
            prg_q <= bus.prg_rom_write;
            chr_q <= bus.chr_rom_write;
            if (any_edge) begin
                mirror_q  <= bus.mirror;
                chr_ram_q <= bus.chr_ram;
            end
        end
    end

    // Idle timer, saturating write counters and the 32 KiB image flag.
    // On a fresh load the counters restart so the triggering write counts
    // as the first one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt    <= '0;
            prg_count_q <= '0;
            chr_count_q <= '0;
            prg_big     <= 1'b0;
        end else begin
            if (any_edge || state_q != LOADING) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (start_load) begin
                prg_count_q <= PRG_COUNT_W'(prg_edge);
                chr_count_q <= CHR_COUNT_W'(chr_edge);
                prg_big     <= prg_edge & bus.rom_addr[14];
            end else begin
                if (prg_edge && !(&prg_count_q)) begin
                    prg_count_q <= prg_count_q + 1'b1;
                end
                if (chr_edge && !(&chr_count_q)) begin
                    chr_count_q <= chr_count_q + 1'b1;
                end
                if (prg_edge && bus.rom_addr[14]) begin
                    prg_big <= 1'b1;
                end
            end
        end
    end

    // CHR write port: the loader always owns it; with CHR RAM enabled the
    // PPU may use it while READY, but loses to a loader write that cycle.
`ifdef CART_CHR_RAM_EN
    logic ppu_we;
    assign ppu_we = (state_q == READY) & chr_ram_q & bus.ppu_wr & ~bus.ppu_addr[13];

    always_comb begin
        chr_we    = chr_edge;
        chr_waddr = CHR_AW'(bus.rom_addr);
        chr_wdata = bus.rom_data;
        if (!chr_edge && ppu_we) begin
            chr_we    = 1'b1;
            chr_waddr = CHR_AW'(bus.ppu_addr[12:0]);
            chr_wdata = bus.ppu_wdata;
        end
    end
`else
    assign chr_we    = chr_edge;
    assign chr_waddr = CHR_AW'(bus.rom_addr);
    assign chr_wdata = bus.rom_data;

    logic unused_ppu_write;
    assign unused_ppu_write = ^{bus.ppu_wr, bus.ppu_wdata, chr_ram_q};
`endif

    // A 16 KiB image ignores CPU A14 so it appears at both $8000 and $C000.
    assign cpu_index = PRG_AW'({prg_big & bus.cpu_addr[14], bus.cpu_addr[13:0]});
    assign cpu_req   = (state_q == READY) & bus.cpu_rd & bus.cpu_addr[15];
    assign ppu_req   = (state_q == READY) & bus.ppu_rd & ~bus.ppu_addr[13];

    cart_dp_ram #(.AW(PRG_AW), .DW(8)) u_prg_ram (
        .clk   (clk),
        .we    (prg_edge),
        .waddr (PRG_AW'(bus.rom_addr)),
        .wdata (bus.rom_data),
        .re    (cpu_req),
        .raddr (cpu_index),
        .rdata (prg_rdata)
    );

    cart_dp_ram #(.AW(CHR_AW), .DW(8)) u_chr_ram (
        .clk   (clk),
        .we    (chr_we),
        .waddr (chr_waddr),
        .wdata (chr_wdata),
        .re    (ppu_req),
        .raddr (CHR_AW'(bus.ppu_addr[12:0])),
        .rdata (chr_rdata)
    );

    // Hit flags track whether last cycle's request was served; a miss
    // forces the registered read data to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_hit_q <= 1'b0;
            ppu_hit_q <= 1'b0;
        end else begin
            cpu_hit_q <= cpu_req;
            ppu_hit_q <= ppu_req;
        end
    end

    assign bus.cpu_data   = cpu_hit_q ? prg_rdata : 8'h00;
    assign bus.cpu_hit    = cpu_hit_q;
    assign bus.ppu_data   = ppu_hit_q ? chr_rdata : 8'h00;
    assign bus.ciram_addr = (mirror_q == MIRROR_VERTICAL) ?
                            {bus.ppu_addr[10], bus.ppu_addr[9:0]} :
                            {bus.ppu_addr[11], bus.ppu_addr[9:0]};
    assign bus.cart_ready = (state_q == READY);
    assign bus.loading    = (state_q == LOADING);
    assign bus.prg_count  = prg_count_q;
    assign bus.chr_count  = chr_count_q;

endmodule

// File: tb/tb_cart_rom_loader.sv
// tb_cart_rom_loader
// Drives directed loader writes and CPU/PPU bus requests into
// cart_rom_loader. Read requests push their expected response onto a
// queue; a monitor pops and compares when the registered read data is due.
// Status outputs are compared directly with hand-computed values.
module tb_cart_rom_loader;
    import nes_cart_pkg::*;

    localparam int TO       = 64;
    localparam int CLK_HALF = 5;

`ifdef CART_CHR_RAM_EN
    localparam logic [7:0] EXP_CHR10 = 8'h3C;
`else
    localparam logic [7:0] EXP_CHR10 = 8'h5A;
`endif

    typedef enum int {OP_PRG, OP_CHR, OP_BOTH, OP_CPU, OP_PPU, OP_PPU_WR} op_t;

    typedef struct {
        logic [7:0] data;
        logic       hit;
        int         id;
    } rd_exp_t;

    logic clk = 1'b0;
    logic reset;

    rd_exp_t cpu_q[$];
    rd_exp_t ppu_q[$];
    int      checks = 0;
    int      errors = 0;
    int      rd_id  = 0;
    logic    cpu_req_seen = 1'b0;
    logic    ppu_req_seen = 1'b0;

    cart_rom_loader_if bus();

    cart_rom_loader #(.IDLE_TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #CLK_HALF clk = ~clk;

    // Remember which requests the DUT sampled at each rising edge.
    always @(posedge clk) begin
        cpu_req_seen <= bus.cpu_rd;
        ppu_req_seen <= bus.ppu_rd;
    end

    // Scoreboard monitor: read data is due on the cycle after a request.
    always @(negedge clk) begin : monitor
        rd_exp_t e;
        if (cpu_req_seen) begin
            checks++;
            if (cpu_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL cpu_read unexpected: data=%02h hit=%0b", bus.cpu_data, bus.cpu_hit);
            end else begin
                e = cpu_q.pop_front();
                if (bus.cpu_data !== e.data || bus.cpu_hit !== e.hit) begin
                    errors++;
                    $display("[TB] FAIL cpu_read#%0d actual data=%02h hit=%0b expected data=%02h hit=%0b",
                             e.id, bus.cpu_data, bus.cpu_hit, e.data, e.hit);
                end
            end
        end
        if (ppu_req_seen) begin
            checks++;
            if (ppu_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL ppu_read unexpected: data=%02h", bus.ppu_data);
            end else begin
                e = ppu_q.pop_front();
                if (bus.ppu_data !== e.data) begin
                    errors++;
                    $display("[TB] FAIL ppu_read#%0d actual data=%02h expected data=%02h",
                             e.id, bus.ppu_data, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input op_t op, input logic [15:0] addr, input logic [7:0] data,
                                 input logic [7:0] exp_data, input logic exp_hit);
        case (op)
            OP_PRG, OP_CHR, OP_BOTH: begin
                bus.rom_addr      = addr;
                bus.rom_data      = data;
                bus.prg_rom_write = (op != OP_CHR);
                bus.chr_rom_write = (op != OP_PRG);
                tick();
                bus.prg_rom_write = 1'b0;
                bus.chr_rom_write = 1'b0;
                tick();
            end
            OP_CPU: begin
                bus.cpu_addr = addr;
                bus.cpu_rd   = 1'b1;
                cpu_q.push_back('{exp_data, exp_hit, rd_id});
                rd_id++;
                tick();
                bus.cpu_rd = 1'b0;
            end
            OP_PPU: begin
                bus.ppu_addr = addr[13:0];
                bus.ppu_rd   = 1'b1;
                ppu_q.push_back('{exp_data, 1'b0, rd_id});
                rd_id++;
                tick();
                bus.ppu_rd = 1'b0;
            end
            default: begin
                bus.ppu_addr  = addr[13:0];
                bus.ppu_wdata = data;
                bus.ppu_wr    = 1'b1;
                tick();
                bus.ppu_wr = 1'b0;
            end
        endcase
    endtask

    task automatic waitReady(input string name);
        int n = 0;
        while (bus.cart_ready !== 1'b1 && n < 4 * TO) begin
            tick();
            n++;
        end
        checkOutput(name, 16'(bus.cart_ready), 16'h1);
    endtask

    task automatic checkCiram(input string name, input logic [13:0] addr, input logic [10:0] expected);
        bus.ppu_addr = addr;
        #1;
        checkOutput(name, 16'(bus.ciram_addr), 16'(expected));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cart_ready"}, 16'(bus.cart_ready), 16'h0);
        checkOutput({tag, "_loading"},    16'(bus.loading),    16'h0);
        checkOutput({tag, "_prg_count"},  16'(bus.prg_count),  16'h0);
        checkOutput({tag, "_chr_count"},  16'(bus.chr_count),  16'h0);
        checkOutput({tag, "_cpu_hit"},    16'(bus.cpu_hit),    16'h0);
        checkOutput({tag, "_cpu_data"},   16'(bus.cpu_data),   16'h0);
        checkOutput({tag, "_ppu_data"},   16'(bus.ppu_data),   16'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish: checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset             = 1'b1;
        bus.rom_data      = 8'h00;
        bus.rom_addr      = 16'h0000;
        bus.prg_rom_write = 1'b0;
        bus.chr_rom_write = 1'b0;
        bus.mirror        = 1'b0;
        bus.chr_ram       = 1'b0;
        bus.cpu_addr      = 16'h0000;
        bus.cpu_rd        = 1'b0;
        bus.ppu_addr      = 14'h0000;
        bus.ppu_rd        = 1'b0;
        bus.ppu_wr        = 1'b0;
        bus.ppu_wdata     = 8'h00;
        repeat (3) tick();
        checkResetValues("reset");
        reset = 1'b0;
        tick();

        // Initial 16 KiB load, vertical mirroring, CHR flagged as RAM.
        bus.mirror  = 1'b1;
        bus.chr_ram = 1'b1;
        applyStimulus(OP_PRG, 16'h0000, 8'h4C, 8'h00, 1'b0);
        checkOutput("loading_after_first_write", 16'(bus.loading), 16'h1);
        applyStimulus(OP_PRG, 16'h3FFF, 8'hA5, 8'h00, 1'b0);
        applyStimulus(OP_CHR, 16'h0010, 8'h5A, 8'h00, 1'b0);
        checkOutput("prg_count_two", 16'(bus.prg_count), 16'h2);
        checkOutput("chr_count_one", 16'(bus.chr_count), 16'h1);

        // A strobe held high for 50 cycles is a single write.
        bus.rom_addr      = 16'h1000;
        bus.rom_data      = 8'h11;
        bus.prg_rom_write = 1'b1;
        repeat (50) tick();
        bus.prg_rom_write = 1'b0;
        tick();
        checkOutput("prg_count_held_strobe", 16'(bus.prg_count), 16'h3);
        checkOutput("still_loading", 16'(bus.loading), 16'h1);

        waitReady("ready_after_load");
        checkOutput("loading_low_when_ready", 16'(bus.loading), 16'h0);

        applyStimulus(OP_CPU, 16'hFFFF, 8'h00, 8'hA5, 1'b1);
        applyStimulus(OP_CPU, 16'hC000, 8'h00, 8'h4C, 1'b1);
        applyStimulus(OP_CPU, 16'h8000, 8'h00, 8'h4C, 1'b1);
        applyStimulus(OP_CPU, 16'h9000, 8'h00, 8'h11, 1'b1);
        applyStimulus(OP_CPU, 16'h7FFF, 8'h00, 8'h00, 1'b0);
        applyStimulus(OP_PPU, 16'h0010, 8'h00, 8'h5A, 1'b0);
        applyStimulus(OP_PPU, 16'h2010, 8'h00, 8'h00, 1'b0);
        tick();

        checkCiram("ciram_vert_2C05", 14'h2C05, 11'h405);
        checkCiram("ciram_vert_2805", 14'h2805, 11'h005);

        // PPU write to CHR while the cartridge is flagged chr_ram.
        applyStimulus(OP_PPU_WR, 16'h0010, 8'h3C, 8'h00, 1'b0);
        applyStimulus(OP_PPU, 16'h0010, 8'h00, EXP_CHR10, 1'b0);
        tick();

        // Reload with a write above 16 KiB, horizontal mirroring, CHR ROM.
        bus.mirror  = 1'b0;
        bus.chr_ram = 1'b0;
        applyStimulus(OP_PRG, 16'h4000, 8'h77, 8'h00, 1'b0);
        checkOutput("reload_cart_ready", 16'(bus.cart_ready), 16'h0);
        checkOutput("reload_loading", 16'(bus.loading), 16'h1);
        checkOutput("reload_prg_count", 16'(bus.prg_count), 16'h1);
        checkOutput("reload_chr_count", 16'(bus.chr_count), 16'h0);
        applyStimulus(OP_CPU, 16'hC000, 8'h00, 8'h00, 1'b0);
        tick();
        checkCiram("ciram_horz_2C05", 14'h2C05, 11'h405);
        checkCiram("ciram_horz_2805", 14'h2805, 11'h405);

        waitReady("ready_after_reload");
        applyStimulus(OP_CPU, 16'hC000, 8'h00, 8'h77, 1'b1);
        applyStimulus(OP_CPU, 16'h8000, 8'h00, 8'h4C, 1'b1);
        applyStimulus(OP_PPU_WR, 16'h0010, 8'h99, 8'h00, 1'b0);
        applyStimulus(OP_PPU, 16'h0010, 8'h00, EXP_CHR10, 1'b0);
        tick();

        // Simultaneous PRG and CHR edges write the same byte to both.
        applyStimulus(OP_BOTH, 16'h0020, 8'hE7, 8'h00, 1'b0);
        checkOutput("both_prg_count", 16'(bus.prg_count), 16'h1);
        checkOutput("both_chr_count", 16'(bus.chr_count), 16'h1);
        waitReady("ready_after_both");
        applyStimulus(OP_CPU, 16'h8020, 8'h00, 8'hE7, 1'b1);
        applyStimulus(OP_CPU, 16'hC000, 8'h00, 8'h4C, 1'b1);
        applyStimulus(OP_PPU, 16'h0020, 8'h00, 8'hE7, 1'b0);
        tick();

        // Reset in the middle of a load.
        applyStimulus(OP_PRG, 16'h0001, 8'h12, 8'h00, 1'b0);
        checkOutput("midload_loading", 16'(bus.loading), 16'h1);
        reset = 1'b1;
        #1;
        checkResetValues("midload_reset");
        tick();
        reset = 1'b0;
        repeat (2 * TO) tick();
        checkOutput("empty_no_timeout", 16'(bus.cart_ready), 16'h0);
        applyStimulus(OP_CPU, 16'h8001, 8'h00, 8'h00, 1'b0);
        tick();
        tick();

        checkOutput("cpu_queue_drained", 16'(cpu_q.size()), 16'h0);
        checkOutput("ppu_queue_drained", 16'(ppu_q.size()), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
